// File: rtl/thirty_two_restoring_divider_pkg.sv
// ----------------------------------------------------------------------------
// thirty_two_restoring_divider_pkg
// Shared definitions for the 64-by-32 restoring divider: FSM state encoding,
// datapath widths and the iteration count.
// ----------------------------------------------------------------------------
package thirty_two_restoring_divider_pkg;

    localparam int DIVIDEND_W = 64;           // dividend width (multiplier product)
    localparam int DIV_W      = 32;           // divisor / quotient / remainder width
    localparam int REM_W      = 33;           // partial remainder R, one guard bit
    localparam int RQ_W       = REM_W + DIV_W; // concatenated {R,Q} shift register
    localparam int ITERS      = 32;           // one quotient bit per step

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/thirty_two_restoring_divider_step.sv
// ----------------------------------------------------------------------------
// restoring_step
// One combinational restoring shift-subtract step.
//   rq_in   : {R[32:0], Q[31:0]} before the step
//   divisor : 32-bit divisor
//   rq_out  : {R, Q} after shift, conditional subtract and quotient bit insert
// ----------------------------------------------------------------------------
module restoring_step
    import thirty_two_restoring_divider_pkg::*;
(
    input  logic [RQ_W-1:0]  rq_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [RQ_W-1:0]  rq_out
);

    logic [RQ_W:0]    sh;      // {R,Q} << 1, keeping the bit shifted out of R
    logic [REM_W-1:0] diff;
    logic             borrow;
    logic             take;

    always_comb begin
        sh             = {rq_in, 1'b0};
        {borrow, diff} = {1'b0, sh[RQ_W-1:DIV_W]} - {2'b0, divisor};
        // The bit shifted past R[32] is always 0 while R < divisor holds; it
        // is folded in so a set bit would still force the subtract.
        take           = ~borrow | sh[RQ_W];
        rq_out         = take ? {diff, sh[DIV_W-1:1], 1'b1}
                              : {sh[RQ_W-1:DIV_W], sh[DIV_W-1:1], 1'b0};
    end

endmodule

// File: rtl/thirty_two_restoring_divider.sv
// ----------------------------------------------------------------------------
// thirty_two_restoring_divider
// Sequential unsigned 64/32 restoring divider, one quotient bit per clock,
// start/busy/done handshake.
//   clk, clear          : clock, async active-high reset
//   start               : request, accepted in IDLE or DONE
//   dividend, divisor   : operands, captured on accept
//   quotient, remainder : registered results, valid from done
//   busy                : iterating; start ignored
//   done                : one-cycle completion pulse
//   div_by_zero         : divisor was zero (valid with done)
//   overflow            : quotient would not fit in 32 bits (valid with done)
// ----------------------------------------------------------------------------
module thirty_two_restoring_divider
    import thirty_two_restoring_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIV_W-1:0]      divisor,
    output logic [DIV_W-1:0]      quotient,
    output logic [DIV_W-1:0]      remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  overflow
);

    div_state_t       state;
    logic [5:0]       cnt;
    logic [RQ_W-1:0]  rq_q;
    logic [RQ_W-1:0]  rq_nxt;
    logic [DIV_W-1:0] dsr_q;

    restoring_step u_step (
        .rq_in   (rq_q),
        .divisor (dsr_q),
        .rq_out  (rq_nxt)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            rq_q        <= '0;
            dsr_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dsr_q       <= divisor;
                        rq_q        <= {1'b0, dividend};
                        cnt         <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DIV_W-1:0];
                        end else if (dividend[DIVIDEND_W-1:DIV_W] >= divisor) begin
                            // Quotient cannot fit in 32 bits: saturate, skip iteration.
                            state     <= DONE;
                            done      <= 1'b1;
                            overflow  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[DIV_W-1:0];
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rq_q <= rq_nxt;
                    cnt  <= cnt + 6'd1;
                    // Results are loaded straight from the final step's output.
                    if (cnt == 6'(ITERS - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= rq_nxt[DIV_W-1:0];
                        remainder <= rq_nxt[RQ_W-2:DIV_W];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thirty_two_restoring_divider.sv
module tb_thirty_two_restoring_divider;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_by_zero, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    thirty_two_restoring_divider dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the exception rules.
    task automatic model(input logic [63:0] dd, input logic [31:0] dv,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
        logic [63:0] q64, r64;
        dz = 1'b0; ov = 1'b0;
        if (dv == 0) begin
            dz = 1'b1; q = 32'hFFFF_FFFF; r = dd[31:0];
        end else if (dd[63:32] >= dv) begin
            ov = 1'b1; q = 32'hFFFF_FFFF; r = dd[31:0];
        end else begin
            q64 = dd / {32'd0, dv};
            r64 = dd % {32'd0, dv};
            q = q64[31:0]; r = r64[31:0];
        end
    endtask

    // Issue one division (DUT must be in IDLE or DONE). Returns just after
    // the edge where done rose. poke>0 re-asserts start with different
    // operands at that RUN cycle; it must be ignored.
    task automatic do_div(input string tag, input logic [63:0] dd,
                          input logic [31:0] dv, input int poke);
        logic [31:0] eq, er;
        logic        ez, eo;
        int          n;
        model(dd, dv, eq, er, ez, eo);
        dividend = dd; divisor = dv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!(ez || eo)) chk({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
            if (poke > 0 && n == poke) begin
                start = 1'b1; dividend = ~dd; divisor = dv ^ 32'h5;
                @(posedge clk); #1; n++;
                start = 1'b0;
            end
        end
        chk({tag, ".lat"}, 64'(n), (ez || eo) ? 64'd0 : 64'd32);
        chk({tag, ".q"},   64'(quotient),    64'(eq));
        chk({tag, ".r"},   64'(remainder),   64'(er));
        chk({tag, ".dz"},  64'(div_by_zero), 64'(ez));
        chk({tag, ".ov"},  64'(overflow),    64'(eo));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] dd;
        clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst.q",  64'(quotient),    64'd0);
        chk("rst.r",  64'(remainder),   64'd0);
        chk("rst.bz", 64'({busy, done, div_by_zero, overflow}), 64'd0);
        @(negedge clk); clear = 1'b0;
        @(posedge clk); #1;

        do_div("basic", 64'd100, 32'd7, 0);
        // done is a single-cycle pulse, results hold afterwards
        @(posedge clk); #1;
        chk("basic.pulse", 64'(done), 64'd0);
        chk("basic.hold",  64'(quotient), 64'd14);

        do_div("inv", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0);
        chk("inv.q", 64'(quotient), 64'hFFFF_FFFF);
        do_div("dz", 64'h1234, 32'd0, 0);
        do_div("ov", 64'h1_0000_0000, 32'd1, 0);
        do_div("poke", 64'd123456789, 32'd1000, 10);

        // Chained: start accepted straight out of DONE, no IDLE gap
        do_div("chain0", 64'd5000, 32'd3, 0);
        do_div("chain1", 64'hABCD_1234_5678, 32'h00FF_FFFF, 0);

        // Multiplier inverse property: (a*b)/b == a, remainder 0
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (b == 0) b = 32'd1;
            dd = {32'd0, a} * {32'd0, b};
            do_div("mul", dd, b, 0);
            chk("mul.a", 64'(quotient),  64'(a));
            chk("mul.z", 64'(remainder), 64'd0);
        end

        // Random operands incl. small divisors that often overflow
        for (int i = 0; i < 12; i++) begin
            dd = {$urandom, $urandom};
            b  = (i % 3 == 0) ? $urandom_range(0, 3) : $urandom;
            if (i % 2 == 0) dd[63:32] = dd[63:32] % (b + 32'd1);
            do_div("rnd", dd, b, 0);
        end

        // Asynchronous clear mid-run
        @(posedge clk); #1;
        dividend = 64'd999999; divisor = 32'd77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (15) @(posedge clk);
        #3 clear = 1'b1;
        #1;
        chk("clr.q", 64'(quotient),  64'd0);
        chk("clr.r", 64'(remainder), 64'd0);
        chk("clr.bz", 64'({busy, done, div_by_zero, overflow}), 64'd0);
        @(negedge clk); clear = 1'b0;
        @(posedge clk); #1;
        do_div("post", 64'd1000, 32'd10, 0);
        chk("post.q", 64'(quotient), 64'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
